// File: rtl/trail_pkg.sv
// Shared types and colour-fade helper for the motion-trail overlay.
package trail_pkg;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        v;
  } pos_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [7:0] sat_sub(input logic [7:0] ch, input int dec);
    int diff;
    diff = int'({24'd0, ch}) - dec;
    if (diff > 0) begin
      return diff[7:0];
    end else begin
      return 8'd0;
    end
  endfunction

  // Per-channel colour of a slot that is 'age' samples old, floored at black.
  function automatic rgb_t fade(input rgb_t base, input int age, input logic [7:0] step);
    int   dec;
    rgb_t res;
    dec   = age * int'({24'd0, step});
    res.r = sat_sub(base.r, dec);
    res.g = sat_sub(base.g, dec);
    res.b = sat_sub(base.b, dec);
    return res;
  endfunction

endpackage

// File: rtl/trail_slot_hit.sv
// Combinational square-membership test for one history slot.
module trail_slot_hit
  import trail_pkg::*;
#(
  parameter int SIDE = 15
) (
  input  pos_t        pos,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic        hit
);

  localparam logic [11:0] SIDE_W = 12'(SIDE);

  logic [11:0] h_s;
  logic [11:0] v_s;
  logic [11:0] x_s;
  logic [11:0] y_s;

  // One extra bit of headroom keeps x+SIDE near 2047 from wrapping to 0.
  assign h_s = {1'b0, hcount};
  assign v_s = {2'b00, vcount};
  assign x_s = {1'b0, pos.x};
  assign y_s = {2'b00, pos.y};

  assign hit = pos.v
             && (h_s >= x_s) && (h_s < (x_s + SIDE_W))
             && (v_s >= y_s) && (v_s < (y_s + SIDE_W));

endmodule

// File: rtl/trail_renderer.sv
// Motion-trail overlay: DEPTH-deep position history drawn as fading squares.
// Optional build macro TRAIL_DEDUP_EN suppresses pushes of a repeated position.
module trail_renderer
  import trail_pkg::*;
#(
  parameter int          DEPTH      = 5,
  parameter int          DECIM      = 1,
  parameter int          SIZE_MAX   = 15,
  parameter int          SIZE_STEP  = 3,
  parameter logic [23:0] BASE_COLOR = 24'hFF_FF_FF,
  parameter logic [7:0]  FADE_STEP  = 8'h22
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         nf_in,
  input  logic                         en_in,
  input  logic                         clear_in,
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic [10:0]                  x_in,
  input  logic [9:0]                   y_in,
  input  logic                         obj_valid_in,
  output logic [23:0]                  color_out,
  output logic                         hit_out,
  output logic [$clog2(DEPTH+1)-1:0]   depth_used_out
);

  localparam int          DU_W    = $clog2(DEPTH + 1);
  localparam logic [7:0]  DC_LAST = 8'(DECIM - 1);

  generate
    if ((SIZE_MAX - (DEPTH - 1) * SIZE_STEP) < 1 || DEPTH < 1 || DEPTH > 16
        || DECIM < 1 || DECIM > 255) begin : g_bad_cfg
      $error("trail_renderer: illegal parameter combination");
    end
  endgenerate

  pos_t            hist_r [DEPTH];
  logic [7:0]      dc_r;
  logic            step_s;
  logic            push_s;
  logic            dup_s;
  logic            shift_s;
  logic [DEPTH-1:0] hit_s;
  logic [23:0]     slot_color_s [DEPTH];
  logic [23:0]     color_s;
  logic [23:0]     color_r;
  logic            hit_r;
  logic [DU_W-1:0] used_s;

  assign step_s = nf_in && en_in;
  assign push_s = step_s && (dc_r == DC_LAST);

`ifdef TRAIL_DEDUP_EN
  assign dup_s = obj_valid_in && hist_r[0].v && (x_in == hist_r[0].x) && (y_in == hist_r[0].y);
`else
  assign dup_s = 1'b0;
`endif

  assign shift_s = push_s && !dup_s;

  // History shift register and decimation counter; clear beats a same-cycle push.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dc_r <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= '0;
      end
    end else if (clear_in) begin
      dc_r <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i].v <= 1'b0;
      end
    end else begin
      if (step_s) begin
        dc_r <= push_s ? 8'd0 : (dc_r + 8'd1);
      end
      if (shift_s) begin
        hist_r[0] <= '{x: x_in, y: y_in, v: obj_valid_in};
        for (int i = 1; i < DEPTH; i++) begin
          hist_r[i] <= hist_r[i-1];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam rgb_t SLOT_COLOR = fade(rgb_t'(BASE_COLOR), gi, FADE_STEP);
      assign slot_color_s[gi] = SLOT_COLOR;
      trail_slot_hit #(
        .SIDE (SIZE_MAX - gi * SIZE_STEP)
      ) u_hit (
        .pos    (hist_r[gi]),
        .hcount (hcount_in),
        .vcount (vcount_in),
        .hit    (hit_s[gi])
      );
    end
  endgenerate

  // Newest-wins priority mux, scanned oldest first so lower indices overwrite.
  always_comb begin
    color_s = 24'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        color_s = slot_color_s[i];
      end else begin
        color_s = color_s;
      end
    end
  end

  // Pixel output register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      color_r <= 24'd0;
      hit_r   <= 1'b0;
    end else begin
      color_r <= color_s;
      hit_r   <= |hit_s;
    end
  end

  // Population count of valid slots.
  always_comb begin
    used_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      used_s = used_s + DU_W'(hist_r[i].v);
    end
  end

  assign color_out      = color_r;
  assign hit_out        = hit_r;
  assign depth_used_out = used_s;

endmodule
